// File: rtl/dac_mcp4921.sv
// -----------------------------------------------------------------------------
// dac_mcp4921
//   SPI write master for the Microchip MCP4921 12-bit DAC. A one-cycle latch
//   strobe captures a 12-bit code. The block then shifts one 16-bit command
//   word MSB first:
//     {1'b0 (DAC A), BUF_BIT, GA_N_BIT, SHDN_N_BIT, code[11:0]}
//   SCK idles low. The DAC samples SDI on each SCK rising edge.
//   A frame is SETUP, 16 x (HIGH, LOW), then GAP. Each phase lasts CLK_DIV
//   system clocks. A strobe that arrives while busy is parked in a one-deep
//   pending buffer, and the last strobe wins. That pending value is sent
//   back-to-back as soon as the GAP phase ends.
//
// Parameters
//   CLK_DIV    : system clocks per SCK half-period (legal 2..255)
//   BUF_BIT    : command bit 14, VREF input buffer enable
//   GA_N_BIT   : command bit 13, 1 = gain x1
//   SHDN_N_BIT : command bit 12, 1 = output active
//
// Ports
//   clk      in   system clock (50 MHz), rising edge
//   reset    in   synchronous active-high reset; aborts any frame
//   latch    in   start request, sampled every clk edge
//   value    in   12-bit DAC code, captured when latch=1
//   cs_dac   out  chip select, active low
//   clk_dac  out  SCK, idle low
//   sdo_dac  out  serial data to the DAC SDI pin
//   ldac_dac out  LDAC, active low
//   busy     out  high from the frame start until the end of its GAP
//
// Build option
//   DAC_MCP4921_LDAC_EN : when defined, ldac_dac idles high and pulses low
//                         during the last max(CLK_DIV/2,1) cycles of GAP.
//                         When undefined, ldac_dac is held at 0. In that case
//                         the DAC updates on the CS rising edge.
// -----------------------------------------------------------------------------
module dac_mcp4921 #(
  parameter int CLK_DIV    = 25,
  parameter bit BUF_BIT    = 1'b0,
  parameter bit GA_N_BIT   = 1'b1,
  parameter bit SHDN_N_BIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        latch,
  input  logic [11:0] value,
  output logic        cs_dac,
  output logic        clk_dac,
  output logic        sdo_dac,
  output logic        ldac_dac,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Last count value of each phase: the "tick".
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [4:0] FRAME_BITS = 5'd16;

`ifdef DAC_MCP4921_LDAC_EN
  localparam int         LDAC_LEN  = ((CLK_DIV / 2) < 1) ? 1 : (CLK_DIV / 2);
  // ldac_dac is registered. It is therefore pulled low one count early, so
  // that it is low for exactly LDAC_LEN cycles at the end of GAP.
  localparam logic [7:0] LDAC_ARM  = 8'(CLK_DIV - LDAC_LEN - 1);
  localparam logic       LDAC_IDLE = 1'b1;
`else
  localparam logic       LDAC_IDLE = 1'b0;
`endif

  // Builds the 16-bit MCP4921 command from a 12-bit code. Bit 15 = 0 selects DAC A.
  function automatic logic [15:0] cmd_word(input logic [11:0] code);
    cmd_word = {1'b0, BUF_BIT, GA_N_BIT, SHDN_N_BIT, code};
  endfunction

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [4:0]  r_bit_cnt;
  logic [15:0] r_shift;
  logic        r_pend;
  logic [11:0] r_pend_val;
  logic        r_cs;
  logic        r_sck;
  logic        r_sdo;
  logic        r_ldac;
  logic        r_busy;

  logic        w_tick;
  logic [15:0] w_new_word;
  logic [11:0] w_gap_code;
  logic [15:0] w_gap_word;

  assign w_tick     = (r_cnt == DIV_LAST);
  assign w_new_word = cmd_word(value);
  // At the final GAP tick, a strobe in that same cycle is the most recent
  // request. It therefore wins over the parked value.
  assign w_gap_code = latch ? value : r_pend_val;
  assign w_gap_word = cmd_word(w_gap_code);

  // Frame sequencer: phase divider, shift register, pending buffer and all pin registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_bit_cnt  <= 5'd0;
      r_shift    <= 16'd0;
      r_pend     <= 1'b0;
      r_pend_val <= 12'd0;
      r_cs       <= 1'b1;
      r_sck      <= 1'b0;
      r_sdo      <= 1'b0;
      r_ldac     <= LDAC_IDLE;
      r_busy     <= 1'b0;
    end else begin
      // Any strobe while a frame is running is parked, and the last one wins.
      // The final GAP tick below consumes the pending value and overrides this.
      if (latch && (r_state != ST_IDLE)) begin
        r_pend     <= 1'b1;
        r_pend_val <= value;
      end

      case (r_state)
        ST_IDLE: begin
          r_cnt <= 8'd0;
          if (latch) begin
            r_state   <= ST_SETUP;
            r_shift   <= {w_new_word[14:0], 1'b0};
            r_sdo     <= w_new_word[15];
            r_bit_cnt <= 5'd0;
            r_cs      <= 1'b0;
            r_sck     <= 1'b0;
            r_busy    <= 1'b1;
          end else begin
            r_cs   <= 1'b1;
            r_busy <= 1'b0;
          end
        end

        ST_SETUP: begin
          if (w_tick) begin
            r_state <= ST_HIGH;
            r_cnt   <= 8'd0;
            r_sck   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        ST_HIGH: begin
          if (w_tick) begin
            r_state   <= ST_LOW;
            r_cnt     <= 8'd0;
            r_sck     <= 1'b0;
            // Present the next bit on the falling edge. Zeros were shifted in
            // behind the word, so SDO reads 0 once bit 0 has been sampled.
            r_sdo     <= r_shift[15];
            r_shift   <= {r_shift[14:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 5'd1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        ST_LOW: begin
          if (w_tick) begin
            r_cnt <= 8'd0;
            if (r_bit_cnt == FRAME_BITS) begin
              r_state <= ST_GAP;
              r_cs    <= 1'b1;
              r_sdo   <= 1'b0;
            end else begin
              r_state <= ST_HIGH;
              r_sck   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        ST_GAP: begin
          if (w_tick) begin
            r_cnt  <= 8'd0;
            r_ldac <= LDAC_IDLE;
            r_pend <= 1'b0;
            if (latch || r_pend) begin
              r_state   <= ST_SETUP;
              r_shift   <= {w_gap_word[14:0], 1'b0};
              r_sdo     <= w_gap_word[15];
              r_bit_cnt <= 5'd0;
              r_cs      <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
`ifdef DAC_MCP4921_LDAC_EN
            if (r_cnt >= LDAC_ARM) begin
              r_ldac <= 1'b0;
            end else begin
              r_ldac <= 1'b1;
            end
`endif
          end
        end

        default: begin
          // An illegal state encoding returns to a quiet, deselected idle.
          r_state   <= ST_IDLE;
          r_cnt     <= 8'd0;
          r_bit_cnt <= 5'd0;
          r_pend    <= 1'b0;
          r_cs      <= 1'b1;
          r_sck     <= 1'b0;
          r_sdo     <= 1'b0;
          r_ldac    <= LDAC_IDLE;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign cs_dac   = r_cs;
  assign clk_dac  = r_sck;
  assign sdo_dac  = r_sdo;
  assign ldac_dac = r_ldac;
  assign busy     = r_busy;

endmodule

// File: tb/tb_dac_mcp4921.sv
// -----------------------------------------------------------------------------
// tb_dac_mcp4921
//   Drives two instances from a shared stimulus stream:
//     dut_a : CLK_DIV=25, default command bits (header 4'b0011)
//     dut_b : CLK_DIV=3, BUF=1, GA_N=0, SHDN_N=0 (header 4'b0100)
//   The reference model tracks each frame as a start edge plus a countdown
//   of cycles left, together with a one-deep last-wins pending value.
//   Expected pin levels are computed arithmetically from the cycle offset j
//   inside the frame:
//     j < D        : SETUP
//     D <= j < 33D : alternating SCK half-periods
//     33D <= j     : GAP
// -----------------------------------------------------------------------------
module tb_dac_mcp4921;

  localparam int DA = 25;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        latch = 1'b0;
  logic [11:0] value = 12'd0;
  logic [1:0]  cs_s, sck_s, sdo_s, ldac_s, busy_s;

  always #5 clk = ~clk;

  dac_mcp4921 #(.CLK_DIV(DA)) dut_a (
    .clk(clk), .reset(reset), .latch(latch), .value(value),
    .cs_dac(cs_s[0]), .clk_dac(sck_s[0]), .sdo_dac(sdo_s[0]),
    .ldac_dac(ldac_s[0]), .busy(busy_s[0])
  );

  dac_mcp4921 #(.CLK_DIV(DB), .BUF_BIT(1'b1), .GA_N_BIT(1'b0), .SHDN_N_BIT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .latch(latch), .value(value),
    .cs_dac(cs_s[1]), .clk_dac(sck_s[1]), .sdo_dac(sdo_s[1]),
    .ldac_dac(ldac_s[1]), .busy(busy_s[1])
  );

  int n_asserts = 0;
  int n_fail    = 0;
  logic chk_on  = 1'b0;

  // Reference model state, one slot per DUT.
  logic        m_busy [2];
  int          m_left [2];
  logic        m_pend [2];
  logic [11:0] m_pval [2];
  logic [15:0] m_word [2];
  logic        m_rst  [2];

  // Frame capture and monitoring state, one slot per DUT.
  logic        p_cs [2], p_sck [2], p_busy [2];
  logic [15:0] cap [2], last_word [2];
  int          rises [2], low_cnt [2], busy_cnt [2];

  function automatic int dv(input int k);
    return (k == 0) ? DA : DB;
  endfunction

  function automatic logic [15:0] mk(input int k, input logic [11:0] v);
    return (k == 0) ? {4'b0011, v} : {4'b0100, v};
  endfunction

  task automatic chk1(input int k, input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d t=%0t: observed %b expected %b", tag, k, $time, obs, exp);
    end
  endtask

  task automatic chk16(input int k, input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d t=%0t: observed %h expected %h", tag, k, $time, obs, exp);
    end
  endtask

  // Advances the model across one rising edge with the given inputs.
  task automatic model_edge(input int k, input logic rst, input logic lat, input logic [11:0] val);
    int full;
    full = 34 * dv(k);
    if (rst) begin
      m_busy[k] = 1'b0; m_left[k] = 0; m_pend[k] = 1'b0;
    end else if (m_busy[k]) begin
      if (m_left[k] == 1) begin
        if (lat) begin
          m_word[k] = mk(k, val); m_left[k] = full; m_pend[k] = 1'b0;
        end else if (m_pend[k]) begin
          m_word[k] = mk(k, m_pval[k]); m_left[k] = full; m_pend[k] = 1'b0;
        end else begin
          m_busy[k] = 1'b0; m_left[k] = 0;
        end
      end else begin
        m_left[k] = m_left[k] - 1;
        if (lat) begin
          m_pend[k] = 1'b1; m_pval[k] = val;
        end
      end
    end else if (lat) begin
      m_busy[k] = 1'b1; m_left[k] = full; m_word[k] = mk(k, val);
    end
    m_rst[k] = rst;
  endtask

  // Compares every pin against the model's expected levels for this cycle.
  task automatic check_dut(input int k);
    int d, j, idx, llen;
    logic e_cs, e_sck, e_sdo, e_ldac;
    logic [15:0] w;
    d = dv(k);
    w = m_word[k];
    llen = ((d / 2) < 1) ? 1 : d / 2;
    e_cs = 1'b1; e_sck = 1'b0; e_sdo = 1'b0;
`ifdef DAC_MCP4921_LDAC_EN
    e_ldac = 1'b1;
`else
    e_ldac = 1'b0;
`endif
    if (m_busy[k]) begin
      j = 34 * d - m_left[k];
      if (j < 33 * d) begin
        e_cs  = 1'b0;
        e_sck = (j >= d) && ((((j - d) / d) % 2) == 0);
        idx   = 15 - j / (2 * d);
        e_sdo = (idx >= 0) ? w[idx[3:0]] : 1'b0;
      end
`ifdef DAC_MCP4921_LDAC_EN
      if (m_left[k] <= llen) e_ldac = 1'b0;
`endif
    end
    chk1(k, "cs_dac", cs_s[k], e_cs);
    chk1(k, "clk_dac", sck_s[k], e_sck);
    chk1(k, "sdo_dac", sdo_s[k], e_sdo);
    chk1(k, "ldac_dac", ldac_s[k], e_ldac);
    chk1(k, "busy", busy_s[k], m_busy[k]);
  endtask

  // Assembles the word seen at SCK rises and checks each completed frame.
  task automatic track(input int k);
    if (p_cs[k] && !cs_s[k]) begin
      cap[k] = 16'd0; rises[k] = 0; low_cnt[k] = 0;
    end
    if (!cs_s[k]) begin
      low_cnt[k]++;
      if (sck_s[k] && !p_sck[k]) begin
        cap[k] = {cap[k][14:0], sdo_s[k]};
        rises[k]++;
      end
    end
    if (!p_cs[k] && cs_s[k] && !m_rst[k]) begin
      chk16(k, "frame_word", cap[k], m_word[k]);
      chk16(k, "sck_rises", 16'(rises[k]), 16'd16);
      chk16(k, "cs_low_len", 16'(low_cnt[k]), 16'(33 * dv(k)));
      last_word[k] = cap[k];
    end
    if (busy_s[k] && !p_busy[k]) busy_cnt[k] = 0;
    if (busy_s[k]) busy_cnt[k]++;
    if (!busy_s[k] && p_busy[k] && !m_rst[k])
      chk16(k, "busy_len_mod", 16'(busy_cnt[k] % (34 * dv(k))), 16'd0);
    p_cs[k] = cs_s[k]; p_sck[k] = sck_s[k]; p_busy[k] = busy_s[k];
  endtask

  task automatic step(input logic rst, input logic lat, input logic [11:0] val);
    @(negedge clk);
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        check_dut(k);
        track(k);
      end
    end
    reset = rst; latch = lat; value = val;
    for (int k = 0; k < 2; k++) model_edge(k, rst, lat, val);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'($urandom_range(0, 4095)));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0; m_left[k] = 0; m_pend[k] = 1'b0; m_pval[k] = 12'd0;
      m_word[k] = 16'd0; m_rst[k] = 1'b0;
      p_cs[k] = 1'b1; p_sck[k] = 1'b0; p_busy[k] = 1'b0;
      cap[k] = 16'd0; last_word[k] = 16'd0;
      rises[k] = 0; low_cnt[k] = 0; busy_cnt[k] = 0;
    end

    // Reset, then check the reset levels on the following cycles.
    step(1'b1, 1'b0, 12'd0);
    chk_on = 1'b1;
    step(1'b1, 1'b0, 12'd0);
    step(1'b1, 1'b0, 12'd0);
    idle(5);

    // Single frame, value 12'h081.
    step(1'b0, 1'b1, 12'h081);
    idle(900);
    chk16(0, "plan_word_3081", last_word[0], 16'h3081);
    chk16(1, "plan_word_4081", last_word[1], 16'h4081);

    // Full-scale code. The configured instance must send 16'h4FFF.
    step(1'b0, 1'b1, 12'hFFF);
    idle(900);
    chk16(1, "plan_cfg_4fff", last_word[1], 16'h4FFF);
    chk16(0, "plan_word_3fff", last_word[0], 16'h3FFF);

    // Back-to-back: ABC is overwritten by 555 before the first frame ends.
    step(1'b0, 1'b1, 12'h123);
    idle(99);
    step(1'b0, 1'b1, 12'hABC);
    idle(299);
    step(1'b0, 1'b1, 12'h555);
    idle(1800);
    chk16(0, "plan_b2b_3555", last_word[0], 16'h3555);
    chk16(1, "plan_b2b_4555", last_word[1], 16'h4555);

    // Reset mid-frame, applied just after the 5th SCK rise of dut_a.
    step(1'b0, 1'b1, 12'h0AA);
    idle(230);
    step(1'b1, 1'b0, 12'd0);
    idle(5);
    step(1'b0, 1'b1, 12'h00F);
    idle(900);
    chk16(0, "plan_after_reset_300f", last_word[0], 16'h300F);

    // Latch held high: continuous frames, each carrying the newest value.
    for (int i = 0; i < 2000; i++) step(1'b0, 1'b1, 12'($urandom_range(0, 4095)));
    idle(900);

    // Random sparse strobes, including strobes while busy.
    for (int i = 0; i < 6000; i++)
      step(1'b0, ($urandom_range(0, 299) == 0), 12'($urandom_range(0, 4095)));
    idle(1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
